// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end for the 9-bit decoder: PC, branch-target LUT, 1-cycle imem reads.
// Optional feature macro: HALT_INSTR_EN (HALT_CODE in ISSUE ends the run without issuing).
module instr_fetch_unit #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_IDX_W = 5,
  parameter logic [INSTR_W-1:0] HALT_CODE = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      prog_end,
  output logic [PC_W-1:0]      imem_addr,
  output logic                 imem_ren,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   instr,
  output logic                 instr_valid,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic [15:0]          instr_count,
  output logic                 done
);

  localparam int unsigned LUT_DEPTH = 1 << LUT_IDX_W;
  localparam int unsigned CNT_W     = 16;

`ifdef HALT_INSTR_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                first_q;
  logic [CNT_W-1:0]    count_q;
  logic [PC_W-1:0]     lut_q [LUT_DEPTH];

  logic [INSTR_W-1:0]  instr_d;
  logic [PC_W:0]       pc_next_d;
  logic                end_run_d;
  logic                halt_hit_d;
  logic [CNT_W-1:0]    count_inc_d;

  // Read data arrives in the first ISSUE cycle; instr_q holds it for any stall cycles after.
  assign instr_d = first_q ? imem_rdata : instr_q;

  assign halt_hit_d = HALT_EN && (state_q == S_ISSUE) && (instr_d == HALT_CODE);

  // Extra top bit catches PC wrap so a run off the end of memory terminates.
  always_comb begin
    pc_next_d   = '0;
    end_run_d   = 1'b0;
    count_inc_d = count_q;
    if (branch_en) begin
      pc_next_d = {1'b0, lut_q[branch_idx]};
    end else begin
      pc_next_d = {1'b0, pc_q} + (PC_W+1)'(1);
    end
    end_run_d = pc_next_d[PC_W] || (pc_next_d[PC_W-1:0] > prog_end);
    if (count_q != {CNT_W{1'b1}}) begin
      count_inc_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      first_q <= 1'b0;
      count_q <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q    <= '0;
            count_q <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          first_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (first_q) begin
            instr_q <= imem_rdata;
          end
          if (halt_hit_d) begin
            state_q <= S_DONE;
          end else if (!stall) begin
            count_q <= count_inc_d;
            if (end_run_d) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_next_d[PC_W-1:0];
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign imem_ren    = (state_q == S_FETCH);
  assign instr       = instr_d;
  assign instr_valid = (state_q == S_ISSUE) && !halt_hit_d;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: issue timing, branches, stalls, range end, reset, halt.
module tb_instr_fetch_unit;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned LUT_IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [PC_W-1:0]      prog_end = '0;
  logic [PC_W-1:0]      imem_addr;
  logic                 imem_ren;
  logic [INSTR_W-1:0]   imem_rdata = '0;
  logic [INSTR_W-1:0]   instr;
  logic                 instr_valid;
  logic                 stall = 1'b0;
  logic                 branch_en = 1'b0;
  logic [LUT_IDX_W-1:0] branch_idx = '0;
  logic                 lut_we = 1'b0;
  logic [LUT_IDX_W-1:0] lut_waddr = '0;
  logic [PC_W-1:0]      lut_wdata = '0;
  logic [PC_W-1:0]      pc;
  logic [15:0]          instr_count;
  logic                 done;

  logic [INSTR_W-1:0] mem [1024];
  int cyc = 0;
  int bad_fetch = 0;
  int n_checks = 0;
  int n_fails = 0;
  int t0;
  int b0;
  logic [INSTR_W-1:0] t1v [4];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .prog_end(prog_end),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .branch_en(branch_en), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .instr_count(instr_count), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mem[imem_addr];
    cyc <= cyc + 1;
    if (imem_ren && imem_addr == 10'h3FF) bad_fetch <= bad_fetch + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pc(input logic [PC_W-1:0] p);
    int n = 0;
    while (!(instr_valid && pc == p) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_pc", 32'(instr_valid && pc == p), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic lut_write(input logic [LUT_IDX_W-1:0] a, input logic [PC_W-1:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    t1v[0] = 9'h003; t1v[1] = 9'h004; t1v[2] = 9'h000; t1v[3] = 9'h001;
    for (int i = 0; i < 4; i++) mem[i] = t1v[i];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_ren", 32'(imem_ren), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Straight-line program, 2 cycles per instruction
    prog_end = 10'd3;
    start_run();
    t0 = cyc;
    check("t1_fetch_ren", 32'(imem_ren), 32'd1);
    check("t1_fetch_addr", 32'(imem_addr), 32'd0);
    check("t1_fetch_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_issue_valid", 32'(instr_valid), 32'd1);
    check("t1_issue_instr", 32'(instr), 32'(t1v[0]));
    check("t1_issue_pc", 32'(pc), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t1_fetch_valid", 32'(instr_valid), 32'd0);
      check("t1_fetch_addr", 32'(imem_addr), 32'(k));
      @(negedge clk);
      check("t1_issue_valid", 32'(instr_valid), 32'd1);
      check("t1_issue_instr", 32'(instr), 32'(t1v[k]));
      check("t1_issue_pc", 32'(pc), 32'(k));
    end
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_count", 32'(instr_count), 32'd4);
    check("t1_valid_off", 32'(instr_valid), 32'd0);
    check("t1_cycles", 32'(cyc - t0), 32'd8);

    // Backward branch taken twice at pc 2
    lut_write(5'd5, 10'd0);
    start_run();
    t0 = cyc;
    for (int l = 0; l < 2; l++) begin
      wait_pc(10'd2);
      branch_en = 1'b1; branch_idx = 5'd5;
      @(negedge clk);
      branch_en = 1'b0;
      check("t2_redirect_addr", 32'(imem_addr), 32'd0);
      check("t2_redirect_ren", 32'(imem_ren), 32'd1);
    end
    wait_done();
    check("t2_count", 32'(instr_count), 32'd10);
    check("t2_cycles", 32'(cyc - t0), 32'd20);

    // Three stall cycles at pc 1
    start_run();
    t0 = cyc;
    wait_pc(10'd1);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_instr", 32'(instr), 32'h004);
      check("t3_stall_pc", 32'(pc), 32'd1);
      check("t3_stall_valid", 32'(instr_valid), 32'd1);
      check("t3_stall_count", 32'(instr_count), 32'd1);
    end
    stall = 1'b0;
    wait_done();
    check("t3_count", 32'(instr_count), 32'd4);
    check("t3_cycles", 32'(cyc - t0), 32'd11);

    // start while running is ignored
    start_run();
    t0 = cyc;
    wait_pc(10'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ign_count", 32'(instr_count), 32'd4);
    check("ign_cycles", 32'(cyc - t0), 32'd8);

    // Branch beyond prog_end ends the run without fetching the target
    for (int i = 0; i < 8; i++) mem[i] = 9'(9'h010 + i);
    lut_write(5'd0, 10'h3FF);
    prog_end = 10'd7;
    b0 = bad_fetch;
    start_run();
    @(negedge clk);
    check("t4_issue_valid", 32'(instr_valid), 32'd1);
    branch_en = 1'b1; branch_idx = 5'd0;
    @(negedge clk);
    branch_en = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_ren", 32'(imem_ren), 32'd0);
    check("t4_count", 32'(instr_count), 32'd1);
    repeat (2) @(negedge clk);
    check("t4_no_fetch", 32'(bad_fetch - b0), 32'd0);

    // Same-cycle LUT write and read returns the old entry
    lut_write(5'd3, 10'd1);
    prog_end = 10'd3;
    start_run();
    @(negedge clk);
    branch_en = 1'b1; branch_idx = 5'd3;
    lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'd2;
    @(negedge clk);
    branch_en = 1'b0; lut_we = 1'b0;
    check("lut_old_value", 32'(imem_addr), 32'd1);
    wait_done();
    start_run();
    @(negedge clk);
    branch_en = 1'b1; branch_idx = 5'd3;
    @(negedge clk);
    branch_en = 1'b0;
    check("lut_new_value", 32'(imem_addr), 32'd2);
    wait_done();
    check("lut_new_count", 32'(instr_count), 32'd3);

    // prog_end = 0 issues exactly one instruction
    prog_end = 10'd0;
    start_run();
    t0 = cyc;
    wait_done();
    check("pe0_count", 32'(instr_count), 32'd1);
    check("pe0_cycles", 32'(cyc - t0), 32'd2);

    // Last address, then PC wrap terminates
    lut_write(5'd1, 10'h3FF);
    mem[1023] = 9'h0AB;
    prog_end = 10'h3FF;
    start_run();
    @(negedge clk);
    branch_en = 1'b1; branch_idx = 5'd1;
    @(negedge clk);
    branch_en = 1'b0;
    check("wrap_fetch_addr", 32'(imem_addr), 32'h3FF);
    @(negedge clk);
    check("wrap_instr", 32'(instr), 32'h0AB);
    check("wrap_pc", 32'(pc), 32'h3FF);
    @(negedge clk);
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_count", 32'(instr_count), 32'd2);

    // Asynchronous reset mid-issue
    for (int i = 0; i < 4; i++) mem[i] = t1v[i];
    prog_end = 10'd3;
    start_run();
    wait_pc(10'd2);
    #2 reset = 1'b1;
    #1;
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_pc", 32'(pc), 32'd0);
    check("t5_instr", 32'(instr), 32'd0);
    check("t5_ren", 32'(imem_ren), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle_ren", 32'(imem_ren), 32'd0);
    start_run();
    check("t5_restart_addr", 32'(imem_addr), 32'd0);
    check("t5_restart_ren", 32'(imem_ren), 32'd1);
    @(negedge clk);
    branch_en = 1'b1; branch_idx = 5'd0;
    @(negedge clk);
    branch_en = 1'b0;
    check("t5_lut_cleared_addr", 32'(imem_addr), 32'd0);
    check("t5_lut_cleared_done", 32'(done), 32'd0);
    wait_done();
    check("t5_count", 32'(instr_count), 32'd5);

    // Halt encoding at pc 1
    mem[0] = 9'h001; mem[1] = 9'h1FF; mem[2] = 9'h002;
    mem[3] = 9'h003; mem[4] = 9'h004; mem[5] = 9'h005;
    prog_end = 10'd5;
    start_run();
    t0 = cyc;
    @(negedge clk);
    check("t6_issue0_valid", 32'(instr_valid), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_instr", 32'(instr), 32'h1FF);
`ifdef HALT_INSTR_EN
    check("t6_halt_valid", 32'(instr_valid), 32'd0);
    wait_done();
    check("t6_count", 32'(instr_count), 32'd1);
    check("t6_cycles", 32'(cyc - t0), 32'd4);
`else
    check("t6_halt_valid", 32'(instr_valid), 32'd1);
    wait_done();
    check("t6_count", 32'(instr_count), 32'd6);
    check("t6_cycles", 32'(cyc - t0), 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
